mux_arb_n: RTL and testbench

//   Parametrised N-input registered multiplexer with per-channel valid/ready handshake.

---
 rtl/mux_arb_n.sv | 131 +++++++++++++
 tb/tb_mux_arb_n.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_n.sv
// N-input registered multiplexer with per-channel valid/ready handshake.
// Channel selection is by external select, fixed priority or round-robin (MODE).
// The granted word is captured into a one-deep output register with its channel index.
module mux_arb_n #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = 2,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk_i,
    input  logic               reset_n,
    input  logic [SELW-1:0]    sel_i,
    input  logic [N-1:0]       in_valid_i,
    input  logic [N*WIDTH-1:0] in_data_i,
    output logic [N-1:0]       in_ready_o,
    output logic               out_valid_o,
    output logic [WIDTH-1:0]   out_data_o,
    output logic [SELW-1:0]    out_chan_o,
    input  logic               out_ready_i
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_chan_q,  out_chan_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    logic             load_en;
    logic             gnt_found;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer;

    // Round-robin search runs on the request vector rotated so rr_ptr sits at bit 0;
    // the offset of the first set bit is then added back with wrap modulo N.
    logic [2*N-1:0]   vld_rot2;
    logic [N-1:0]     vld_rot;
    logic [SELW:0]    rr_ofs;
    logic [SELW:0]    rr_sum;

    assign load_en = !out_valid_q || out_ready_i;

    // Grant selection for the configured arbitration mode
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        vld_rot2  = {in_valid_i, in_valid_i} >> rr_ptr_q;
        vld_rot   = vld_rot2[N-1:0];
        rr_ofs    = '0;
        rr_sum    = '0;
        if (MODE == 0) begin
            // sel_i values >= N never match any k, so they never grant
            for (int k = 0; k < N; k++) begin
                if ((SELW'(k) == sel_i) && in_valid_i[k]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = SELW'(k);
                end
            end
        end else if (MODE == 1) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (in_valid_i[k]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = SELW'(k);
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (vld_rot[k]) begin
                    gnt_found = 1'b1;
                    rr_ofs    = (SELW + 1)'(k);
                end
            end
            rr_sum = {1'b0, rr_ptr_q} + rr_ofs;
            if (rr_sum >= (SELW + 1)'(N)) begin
                rr_sum = rr_sum - (SELW + 1)'(N);
            end
            gnt_idx = rr_sum[SELW-1:0];
        end
    end

    // Data mux for the granted channel and one-hot ready (forced low while in reset)
    always_comb begin
        gnt_data   = '0;
        in_ready_o = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_idx == SELW'(k)) begin
                gnt_data      = in_data_i[k*WIDTH +: WIDTH];
                in_ready_o[k] = reset_n && load_en && gnt_found;
            end
        end
    end

    assign xfer = gnt_found && load_en;

    // Next-state for the output stage and round-robin pointer
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_chan_d  = gnt_idx;
            if (MODE == 2) begin
                rr_ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; async reset discards any pending output word
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_chan_o  = out_chan_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: one instance per arbitration mode plus a 3-channel round-robin.
// A cycle model predicts grants; expected words are queued at grant and compared at output.
module tb_mux_arb_n;

    logic       clk_i = 1'b0;
    logic       reset_n;
    logic [1:0] sel   [4];
    logic [3:0] vld   [4];
    logic [31:0] dat  [4];
    logic       ordy  [4];

    logic [3:0] irdy   [4];
    logic       ovalid [4];
    logic [7:0] odata  [4];
    logic [1:0] ochan  [4];

    wire [3:0] u0_irdy, u1_irdy, u2_irdy;
    wire [2:0] u3_irdy;
    wire       u0_ov, u1_ov, u2_ov, u3_ov;
    wire [7:0] u0_od, u1_od, u2_od, u3_od;
    wire [1:0] u0_oc, u1_oc, u2_oc, u3_oc;

    int total = 0;
    int bad   = 0;

    bit         m_valid [4];
    int         m_rr    [4];
    logic [9:0] sbq [$];

    always #5 clk_i = ~clk_i;

    mux_arb_n #(.N(4), .WIDTH(8), .MODE(0)) u0 (
        .clk_i(clk_i), .reset_n(reset_n), .sel_i(sel[0]), .in_valid_i(vld[0]),
        .in_data_i(dat[0]), .in_ready_o(u0_irdy), .out_valid_o(u0_ov),
        .out_data_o(u0_od), .out_chan_o(u0_oc), .out_ready_i(ordy[0]));
    mux_arb_n #(.N(4), .WIDTH(8), .MODE(1)) u1 (
        .clk_i(clk_i), .reset_n(reset_n), .sel_i(sel[1]), .in_valid_i(vld[1]),
        .in_data_i(dat[1]), .in_ready_o(u1_irdy), .out_valid_o(u1_ov),
        .out_data_o(u1_od), .out_chan_o(u1_oc), .out_ready_i(ordy[1]));
    mux_arb_n #(.N(4), .WIDTH(8), .MODE(2)) u2 (
        .clk_i(clk_i), .reset_n(reset_n), .sel_i(sel[2]), .in_valid_i(vld[2]),
        .in_data_i(dat[2]), .in_ready_o(u2_irdy), .out_valid_o(u2_ov),
        .out_data_o(u2_od), .out_chan_o(u2_oc), .out_ready_i(ordy[2]));
    mux_arb_n #(.N(3), .WIDTH(8), .MODE(2)) u3 (
        .clk_i(clk_i), .reset_n(reset_n), .sel_i(sel[3]), .in_valid_i(vld[3][2:0]),
        .in_data_i(dat[3][23:0]), .in_ready_o(u3_irdy), .out_valid_o(u3_ov),
        .out_data_o(u3_od), .out_chan_o(u3_oc), .out_ready_i(ordy[3]));

    always_comb begin
        irdy[0] = u0_irdy;  ovalid[0] = u0_ov;  odata[0] = u0_od;  ochan[0] = u0_oc;
        irdy[1] = u1_irdy;  ovalid[1] = u1_ov;  odata[1] = u1_od;  ochan[1] = u1_oc;
        irdy[2] = u2_irdy;  ovalid[2] = u2_ov;  odata[2] = u2_od;  ochan[2] = u2_oc;
        irdy[3] = {1'b0, u3_irdy}; ovalid[3] = u3_ov; odata[3] = u3_od; ochan[3] = u3_oc;
    end

    // Called just after inputs are driven at the falling edge; returns at the next rising edge.
    task automatic step(input int id, input int n, input int mode);
        bit         found;
        int         g;
        int         k;
        bit         load_en;
        logic [3:0] exp_rdy;
        #1;
        load_en = !m_valid[id] || ordy[id];
        found   = 1'b0;
        g       = 0;
        for (int i = 0; i < n; i++) begin
            if (mode == 0) k = i;
            else if (mode == 1) k = i;
            else k = (m_rr[id] + i) % n;
            if (mode == 0) begin
                if (!found && int'(sel[id]) == k && k < n && vld[id][k]) begin found = 1'b1; g = k; end
            end else begin
                if (!found && vld[id][k]) begin found = 1'b1; g = k; end
            end
        end
        exp_rdy = (found && load_en) ? (4'b0001 << g) : 4'b0000;
        total++;
        if (irdy[id] !== exp_rdy) begin
            bad++;
            $display("FAIL in_ready inst=%0d got=%b want=%b t=%0t", id, irdy[id], exp_rdy, $time);
        end
        total++;
        if (ovalid[id] !== m_valid[id]) begin
            bad++;
            $display("FAIL out_valid inst=%0d got=%b want=%b t=%0t", id, ovalid[id], m_valid[id], $time);
        end
        if (m_valid[id]) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL sb_empty inst=%0d got=%h want=queued word t=%0t", id, odata[id], $time);
            end else if ({ochan[id], odata[id]} !== sbq[0]) begin
                bad++;
                $display("FAIL out_word inst=%0d got=%0d:%h want=%0d:%h t=%0t", id, ochan[id], odata[id],
                         sbq[0][9:8], sbq[0][7:0], $time);
            end
            if (ordy[id] && sbq.size() != 0) void'(sbq.pop_front());
        end
        if (found && load_en) begin
            sbq.push_back({2'(g), dat[id][g*8 +: 8]});
            m_valid[id] = 1'b1;
            if (mode == 2) m_rr[id] = (g == n - 1) ? 0 : g + 1;
        end else if (ordy[id]) begin
            m_valid[id] = 1'b0;
        end
        @(posedge clk_i);
    endtask

    task automatic drain(input int id, input int n, input int mode);
        @(negedge clk_i);
        vld[id]  = '0;
        ordy[id] = 1'b1;
        step(id, n, mode);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain_left inst=%0d got=%0d want=0", id, sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ovalid[i] !== 1'b0 || odata[i] !== 8'h00 || ochan[i] !== 2'd0) begin
                bad++;
                $display("FAIL reset_state inst=%0d got=%b/%h/%0d want=0/00/0", i, ovalid[i], odata[i], ochan[i]);
            end
        end
        vld[2]  = 4'b1111;
        dat[2]  = 32'h44332211;
        ordy[2] = 1'b0;
        step(2, 4, 2);
        @(negedge clk_i);
        total++;
        if (ovalid[2] !== 1'b1 || odata[2] !== 8'h11) begin
            bad++;
            $display("FAIL pre_reset_word got=%b/%h want=1/11", ovalid[2], odata[2]);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (ovalid[2] !== 1'b0 || odata[2] !== 8'h00 || ochan[2] !== 2'd0) begin
            bad++;
            $display("FAIL async_reset_out got=%b/%h/%0d want=0/00/0", ovalid[2], odata[2], ochan[2]);
        end
        total++;
        if (irdy[2] !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset_ready got=%b want=0000", irdy[2]);
        end
        @(negedge clk_i);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_rr[i]    = 0;
            vld[i]     = '0;
            ordy[i]    = 1'b1;
        end
        sbq.delete();
    endtask

    task automatic test_mode0();
        @(negedge clk_i);
        sel[0] = 2'd2; vld[0] = 4'b0100; dat[0] = 32'h00A50000; ordy[0] = 1'b1;
        step(0, 4, 0);
        @(negedge clk_i);
        total++;
        if (odata[0] !== 8'hA5 || ochan[0] !== 2'd2) begin
            bad++;
            $display("FAIL mode0_word got=%h/%0d want=a5/2", odata[0], ochan[0]);
        end
        sel[0] = 2'd1;
        step(0, 4, 0);
        @(negedge clk_i);
        total++;
        if (ovalid[0] !== 1'b0) begin
            bad++;
            $display("FAIL mode0_noload got=%b want=0", ovalid[0]);
        end
        sel[0] = 2'd3; vld[0] = 4'b1000; dat[0] = 32'h7E000000;
        step(0, 4, 0);
        drain(0, 4, 0);
    endtask

    task automatic test_mode1();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            vld[1]  = 4'b1010;
            dat[1]  = {8'hE0 + 8'(i), 8'h00, 8'hC0 + 8'(i), 8'h00};
            ordy[1] = 1'b1;
            if (i > 0) begin
                total++;
                if (ochan[1] !== 2'd1 || odata[1] !== 8'hC0 + 8'(i - 1)) begin
                    bad++;
                    $display("FAIL mode1_prio got=%0d/%h want=1/%h", ochan[1], odata[1], 8'hC0 + 8'(i - 1));
                end
            end
            step(1, 4, 1);
        end
        drain(1, 4, 1);
    endtask

    task automatic test_mode2_rr();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            vld[2]  = 4'b1111;
            dat[2]  = {8'h40 + 8'(i), 8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i)};
            ordy[2] = 1'b1;
            if (i > 0) begin
                total++;
                if (ovalid[2] !== 1'b1 || ochan[2] !== 2'((i - 1) % 4)) begin
                    bad++;
                    $display("FAIL rr_seq got=%b/%0d want=1/%0d", ovalid[2], ochan[2], (i - 1) % 4);
                end
            end
            step(2, 4, 2);
        end
        drain(2, 4, 2);
    endtask

    task automatic test_stall();
        @(negedge clk_i);
        vld[2] = 4'b1111; dat[2] = 32'hDDCCBBAA; ordy[2] = 1'b1;
        step(2, 4, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            ordy[2] = 1'b0;
            total++;
            if (ovalid[2] !== 1'b1 || odata[2] !== 8'hAA || ochan[2] !== 2'd0) begin
                bad++;
                $display("FAIL stall_hold got=%b/%h/%0d want=1/aa/0", ovalid[2], odata[2], ochan[2]);
            end
            step(2, 4, 2);
        end
        @(negedge clk_i);
        ordy[2] = 1'b1;
        #1;
        total++;
        if (irdy[2] !== 4'b0010) begin
            bad++;
            $display("FAIL stall_release_ready got=%b want=0010", irdy[2]);
        end
        step(2, 4, 2);
        @(negedge clk_i);
        total++;
        if (ovalid[2] !== 1'b1 || odata[2] !== 8'hBB || ochan[2] !== 2'd1) begin
            bad++;
            $display("FAIL stall_next_word got=%b/%h/%0d want=1/bb/1", ovalid[2], odata[2], ochan[2]);
        end
        vld[2] = '0;
        step(2, 4, 2);
        sbq.delete();
    endtask

    task automatic test_wrap_n3();
        @(negedge clk_i);
        vld[3] = 4'b0100; dat[3] = 32'h00C2B1A0; ordy[3] = 1'b1;
        step(3, 3, 2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            vld[3] = 4'b0101;
            total++;
            if (i == 0) begin
                if (ochan[3] !== 2'd2 || odata[3] !== 8'hC2) begin
                    bad++;
                    $display("FAIL wrap_first got=%0d/%h want=2/c2", ochan[3], odata[3]);
                end
            end else if (ochan[3] !== (((i - 1) % 2 == 0) ? 2'd0 : 2'd2)) begin
                bad++;
                $display("FAIL wrap_alt got=%0d want=%0d", ochan[3], ((i - 1) % 2 == 0) ? 0 : 2);
            end
            step(3, 3, 2);
        end
        drain(3, 3, 2);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel[i] = '0; vld[i] = '0; dat[i] = '0; ordy[i] = 1'b1;
            m_valid[i] = 1'b0; m_rr[i] = 0;
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_n = 1'b1;
        test_reset();
        test_mode0();
        test_mode1();
        test_mode2_rr();
        test_stall();
        test_wrap_n3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
